seven_segment_display_driver: RTL and testbench

SEVEN_SEGMENT_DISPLAY_DRIVER -- requirements
Module: seven_segment_display_driver

---
 rtl/seven_segment_display_driver_if.sv | 24 ++
 rtl/seven_segment_display_driver.sv | 160 ++++++++++++++++
 tb/tb_seven_segment_display_driver.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seven_segment_display_driver_if.sv
// Display driver bus: load request with value/mode, busy/overflow status, active-low segments.
// Loads are accepted only while out_busy is low; all outputs come from registers.
interface seven_segment_display_driver_if #(
  parameter int NUM_DIGITS = 6
);
  logic [4*NUM_DIGITS-1:0] in_value;
  logic                    in_load;
  logic                    in_mode_decimal;
  logic                    in_blank_leading_zeros;
  logic                    in_blink_enable;
  logic                    out_busy;
  logic                    out_overflow;
  logic [7*NUM_DIGITS-1:0] out_seven_segment;

  modport master (
    output in_value, in_load, in_mode_decimal, in_blank_leading_zeros, in_blink_enable,
    input  out_busy, out_overflow, out_seven_segment
  );

  modport slave (
    input  in_value, in_load, in_mode_decimal, in_blank_leading_zeros, in_blink_enable,
    output out_busy, out_overflow, out_seven_segment
  );
endinterface

// File: rtl/seven_segment_display_driver.sv
// Multi-digit 7-segment driver: hex shows 1 edge after load; decimal runs a double-dabble
// conversion for 4*NUM_DIGITS cycles (busy), loads ignored while busy; blink and blanking on top.
module seven_segment_display_driver #(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25000000
) (
  input logic                           clk,
  input logic                           reset_n,
  seven_segment_display_driver_if.slave bus
);
  localparam int VW = 4 * NUM_DIGITS;
  localparam int SW = 7 * NUM_DIGITS;
  localparam int CW = $clog2(VW);
  localparam int PW = $clog2(BLINK_DIV);
  localparam logic [VW-1:0] MAX_DEC   = VW'(10 ** NUM_DIGITS - 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(VW - 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(BLINK_DIV - 1);

  typedef enum logic {S_IDLE, S_CONV} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            w_busy;
  logic            w_accept;
  logic            w_in_ovf;
  logic            w_conv_start;
  logic [VW-1:0]   r_digits;
  logic [VW-1:0]   r_bin;
  logic [VW-1:0]   r_bcd;
  logic [VW-1:0]   w_bcd_adj;
  logic [VW-1:0]   w_bcd_next;
  logic [CW-1:0]   r_step;
  logic            r_overflow;
  logic            r_blank;
  logic            r_blank_pend;
  logic [PW-1:0]   r_presc;
  logic            r_phase;
  logic [SW-1:0]   w_seg;
  logic            w_seen;

  function automatic logic [6:0] f_decode(input logic [3:0] d);
    f_decode = 7'b1111111;
    case (d)
      4'h0: f_decode = 7'b1000000;
      4'h1: f_decode = 7'b1111001;
      4'h2: f_decode = 7'b0100100;
      4'h3: f_decode = 7'b0110000;
      4'h4: f_decode = 7'b0011001;
      4'h5: f_decode = 7'b0010010;
      4'h6: f_decode = 7'b0000010;
      4'h7: f_decode = 7'b1111000;
      4'h8: f_decode = 7'b0000000;
      4'h9: f_decode = 7'b0011000;
      4'hA: f_decode = 7'b0001000;
      4'hB: f_decode = 7'b0000011;
      4'hC: f_decode = 7'b0100111;
      4'hD: f_decode = 7'b0100001;
      4'hE: f_decode = 7'b0000110;
      4'hF: f_decode = 7'b0001110;
    endcase
  endfunction

  assign w_accept     = bus.in_load && !w_busy;
  assign w_in_ovf     = bus.in_value > MAX_DEC;
  assign w_conv_start = w_accept && bus.in_mode_decimal && !w_in_ovf;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_conv_start) w_state_next = S_CONV;
      S_CONV:  if (r_step == LAST_STEP) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state == S_CONV);
  end

  // Add-3 correction precedes each shift so the final shift leaves a clean BCD result.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
    w_bcd_next = {w_bcd_adj[VW-2:0], r_bin[VW-1]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_digits     <= '0;
      r_bin        <= '0;
      r_bcd        <= '0;
      r_step       <= '0;
      r_overflow   <= 1'b0;
      r_blank      <= 1'b0;
      r_blank_pend <= 1'b0;
    end else if (w_accept) begin
      r_blank_pend <= bus.in_blank_leading_zeros;
      if (!bus.in_mode_decimal) begin
        r_digits   <= bus.in_value;
        r_overflow <= 1'b0;
        r_blank    <= bus.in_blank_leading_zeros;
      end else if (w_in_ovf) begin
        r_overflow <= 1'b1;
        r_blank    <= bus.in_blank_leading_zeros;
      end else begin
        r_bin  <= bus.in_value;
        r_bcd  <= '0;
        r_step <= '0;
      end
    end else if (w_busy) begin
      r_bin  <= {r_bin[VW-2:0], 1'b0};
      r_bcd  <= w_bcd_next;
      r_step <= r_step + CW'(1);
      // The old digits and blanking stay visible until the full result is ready.
      if (r_step == LAST_STEP) begin
        r_digits   <= w_bcd_next;
        r_overflow <= 1'b0;
        r_blank    <= r_blank_pend;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
      r_phase <= 1'b0;
    end else if (!bus.in_blink_enable) begin
      r_presc <= '0;
      r_phase <= 1'b0;
    end else if (r_presc == PRESC_MAX) begin
      r_presc <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  always_comb begin
    w_seg  = '1;
    w_seen = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (r_digits[4*i +: 4] != 4'd0) w_seen = 1'b1;
      if (r_phase)                            w_seg[7*i +: 7] = 7'b1111111;
      else if (r_overflow)                    w_seg[7*i +: 7] = 7'b0111111;
      else if (r_blank && !w_seen && i != 0)  w_seg[7*i +: 7] = 7'b1111111;
      else                                    w_seg[7*i +: 7] = f_decode(r_digits[4*i +: 4]);
    end
  end

  assign bus.out_busy          = w_busy;
  assign bus.out_overflow      = r_overflow;
  assign bus.out_seven_segment = w_seg;
endmodule

// File: tb/tb_seven_segment_display_driver.sv
// Random + directed loads against an arithmetic display model; a queue-fed monitor
// compares results when they appear and checks the display holds in between.
module tb_seven_segment_display_driver;
  localparam int N  = 6;
  localparam int NB = 4 * N;
  localparam int BD = 4;

  typedef struct {
    bit             conv;
    int             due;
    logic [7*N-1:0] seg;
    bit             ovf;
  } exp_t;

  logic clk;
  logic reset_n;
  seven_segment_display_driver_if #(.NUM_DIGITS(N)) bus();

  seven_segment_display_driver #(.NUM_DIGITS(N), .BLINK_DIV(BD)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  exp_t           q[$];
  int             cyc = 0;
  int             n_checks = 0;
  int             n_bad = 0;
  int             busy_cnt = 0;
  bit             blink_test = 0;
  bit             shown_ovf = 0;
  logic [7*N-1:0] shown;
  logic [7*N-1:0] reset_disp;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;   1: return 7'b1111001;   2: return 7'b0100100;   3: return 7'b0110000;
      4: return 7'b0011001;   5: return 7'b0010010;   6: return 7'b0000010;   7: return 7'b1111000;
      8: return 7'b0000000;   9: return 7'b0011000;  10: return 7'b0001000;  11: return 7'b0000011;
      12: return 7'b0100111; 13: return 7'b0100001;  14: return 7'b0000110;  15: return 7'b0001110;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected display of one load, computed digit-by-digit with plain division.
  function automatic exp_t model(input logic [NB-1:0] v, input bit dec, input bit blk);
    exp_t e;
    int   d[N];
    int   msd;
    int   maxv;
    maxv   = 10 ** N - 1;
    e.due  = 0;
    e.ovf  = dec && (int'(v) > maxv);
    e.conv = dec && !e.ovf;
    e.seg  = '1;
    if (e.ovf) begin
      for (int i = 0; i < N; i++) e.seg[7*i +: 7] = 7'b0111111;
      return e;
    end
    msd = 0;
    for (int i = 0; i < N; i++) begin
      d[i] = dec ? (int'(v) / (10 ** i)) % 10 : (int'(v) >> (4 * i)) % 16;
      if (d[i] != 0) msd = i;
    end
    for (int i = 0; i < N; i++) e.seg[7*i +: 7] = (blk && i > msd) ? 7'b1111111 : seg_of(d[i]);
    return e;
  endfunction

  // Called just after a rising edge; returns just after the edge that samples the load.
  task automatic issue(input logic [NB-1:0] v, input bit dec, input bit blk, input bit accepted);
    exp_t e;
    bus.in_value               = v;
    bus.in_mode_decimal        = dec;
    bus.in_blank_leading_zeros = blk;
    bus.in_load                = 1'b1;
    if (accepted) begin
      e     = model(v, dec, blk);
      e.due = cyc + 1;
      q.push_back(e);
    end
    @(posedge clk); #1;
    bus.in_load                = 1'b0;
    bus.in_value               = NB'($urandom);
    bus.in_mode_decimal        = 1'($urandom);
    bus.in_blank_leading_zeros = 1'($urandom);
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int k = 0; k < max_cycles && q.size() > 0; k++) @(posedge clk);
    check("drain_timeout", 64'(q.size()), 64'd0);
    q.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        busy_cnt = 0;
      end else if (!blink_test) begin
        if (q.size() > 0 && q[0].conv) begin
          if (bus.out_busy) begin
            busy_cnt++;
            check("hold_while_busy", 64'(bus.out_seven_segment), 64'(shown));
          end else if (busy_cnt > 0) begin
            check("busy_len", 64'(busy_cnt), 64'(NB));
            check("conv_result", 64'({bus.out_overflow, bus.out_seven_segment}), 64'({1'b0, q[0].seg}));
            shown     = q[0].seg;
            shown_ovf = 1'b0;
            busy_cnt  = 0;
            void'(q.pop_front());
          end else if (cyc >= q[0].due) begin
            check("busy_rise", 64'(bus.out_busy), 64'd1);
            void'(q.pop_front());
          end else begin
            check("pre_load", 64'(bus.out_seven_segment), 64'(shown));
          end
        end else if (q.size() > 0) begin
          if (cyc >= q[0].due) begin
            check("load_result", 64'({bus.out_busy, bus.out_overflow, bus.out_seven_segment}),
                  64'({1'b0, q[0].ovf, q[0].seg}));
            shown     = q[0].seg;
            shown_ovf = q[0].ovf;
            void'(q.pop_front());
          end else begin
            check("pre_load", 64'(bus.out_seven_segment), 64'(shown));
          end
        end else begin
          check("idle", 64'({bus.out_busy, bus.out_overflow, bus.out_seven_segment}),
                64'({1'b0, shown_ovf, shown}));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion want finish by time 400000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NB-1:0]  v;
    logic [7*N-1:0] want;
    bit             dec;
    bit             blk;
    int             sel;
    reset_disp = {N{7'b1000000}};
    shown      = reset_disp;
    reset_n                    = 1'b0;
    bus.in_value               = '0;
    bus.in_load                = 1'b0;
    bus.in_mode_decimal        = 1'b0;
    bus.in_blank_leading_zeros = 1'b0;
    bus.in_blink_enable        = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    issue(24'h12AB0F, 1'b0, 1'b0, 1'b1);
    wait_drain(10);

    // Decimal load, an ignored load while busy, then a load right after busy falls.
    issue(24'd1234, 1'b1, 1'b1, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    issue(24'd777, 1'b1, 1'b0, 1'b0);
    repeat (18) @(posedge clk);
    #1;
    issue(24'h000005, 1'b0, 1'b1, 1'b1);
    wait_drain(60);

    issue(24'd1000000, 1'b1, 1'b0, 1'b1);
    wait_drain(10);
    issue(24'd999999, 1'b1, 1'b1, 1'b1);
    wait_drain(60);
    issue(24'd0, 1'b1, 1'b1, 1'b1);
    wait_drain(60);
    issue(24'h000A00, 1'b0, 1'b1, 1'b1);
    wait_drain(10);

    blink_test          = 1'b1;
    bus.in_blink_enable = 1'b1;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      want = (((j / BD) % 2) == 1) ? '1 : shown;
      check("blink", 64'(bus.out_seven_segment), 64'(want));
    end
    @(posedge clk); #1;
    bus.in_blink_enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("blink_off", 64'(bus.out_seven_segment), 64'(shown));
    @(posedge clk); #1;
    blink_test = 1'b0;

    // Reset during busy cycle 10: only the reset display may follow.
    issue(24'd123456, 1'b1, 1'b0, 1'b1);
    repeat (9) @(posedge clk);
    #1;
    reset_n = 1'b0;
    q.delete();
    shown     = reset_disp;
    shown_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;

    for (int it = 0; it < 25; it++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       begin v = NB'($urandom);                  dec = 1'b0; end
        1:       begin v = NB'($urandom_range(0, 999999)); dec = 1'b1; end
        2:       begin v = NB'($urandom);                  dec = 1'b1; end
        default: begin v = NB'($urandom_range(0, 99));     dec = 1'b1; end
      endcase
      blk = 1'($urandom);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      issue(v, dec, blk, 1'b1);
      wait_drain(60);
    end

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
